// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared types for the RV32I pipeline stall/flush controller.
//   PipeCtrlState - sequencer state, also exported on o_State for debug.
//   REG_ZERO      - architectural zero register (x0), never a hazard source.
package pipeline_controller_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DMEM_WAIT = 2'd1,
      FAULT     = 2'd2
   } PipeCtrlState;

   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipeline_controller_hazard_detector.sv
// hazard_detector: combinational load-use detection for the instruction in ID.
// A source register matches a pending load destination in EX or MEM; x0 never matches.
//   i_ID_RS1/i_ID_RS2, i_ID_UsesRS1/i_ID_UsesRS2 - ID source registers and their use flags
//   i_EX_IsLoad/i_EX_RegWrAddr                 - load in EX and its destination
//   i_MEM_IsLoad/i_MEM_RegWrAddr               - load in MEM and its destination
//   o_LoadUse                                   - ID must stall
module hazard_detector
   import pipeline_controller_pkg::*;
#(
   parameter int unsigned REG_WIDTH = 5
) (
   input  logic [REG_WIDTH-1:0] i_ID_RS1,
   input  logic [REG_WIDTH-1:0] i_ID_RS2,
   input  logic                 i_ID_UsesRS1,
   input  logic                 i_ID_UsesRS2,
   input  logic                 i_EX_IsLoad,
   input  logic [REG_WIDTH-1:0] i_EX_RegWrAddr,
   input  logic                 i_MEM_IsLoad,
   input  logic [REG_WIDTH-1:0] i_MEM_RegWrAddr,
   output logic                 o_LoadUse
);

   localparam logic [REG_WIDTH-1:0] ZeroAddr = REG_WIDTH'(REG_ZERO);

   logic rs1_live, rs2_live, ex_hit, mem_hit;

   // A source read of x0 can never depend on a load.
   assign rs1_live = i_ID_UsesRS1 && (i_ID_RS1 != ZeroAddr);
   assign rs2_live = i_ID_UsesRS2 && (i_ID_RS2 != ZeroAddr);

   assign ex_hit  = i_EX_IsLoad && ((rs1_live && (i_ID_RS1 == i_EX_RegWrAddr)) ||
                                    (rs2_live && (i_ID_RS2 == i_EX_RegWrAddr)));
   assign mem_hit = i_MEM_IsLoad && ((rs1_live && (i_ID_RS1 == i_MEM_RegWrAddr)) ||
                                     (rs2_live && (i_ID_RS2 == i_MEM_RegWrAddr)));

   assign o_LoadUse = ex_hit || mem_hit;

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer for the 5-stage RV32I pipeline.
// Freezes the pipe on data-memory wait states, stalls ID on load-use hazards, squashes
// wrong-path fetches after ID redirects and raises a sticky fault if a data access waits
// TIMEOUT_CYCLES cycles. Outputs are combinational from registered state and inputs.
//   i_Clock, i_Reset (async, active low)
//   i_ID_*, i_EX_*, i_MEM_*        - hazard sources and redirect request
//   i_DMemReady, i_IMemReady       - memory handshakes
//   o_PCEnable, o_*_Enable         - PC / pipeline register load enables
//   o_*_Flush                      - load a bubble into the register
//   o_Fault, o_State               - watchdog fault and debug state
// Optional macro PIPECTRL_PERF_EN adds o_StallCycles, o_FlushCount, o_WaitCycles.
module pipeline_controller
   import pipeline_controller_pkg::*;
#(
   parameter int unsigned REG_WIDTH      = 5,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [REG_WIDTH-1:0] i_ID_RS1,
   input  logic [REG_WIDTH-1:0] i_ID_RS2,
   input  logic                 i_ID_UsesRS1,
   input  logic                 i_ID_UsesRS2,
   input  logic                 i_ID_Redirect,
   input  logic                 i_EX_IsLoad,
   input  logic [REG_WIDTH-1:0] i_EX_RegWrAddr,
   input  logic                 i_MEM_IsLoad,
   input  logic [REG_WIDTH-1:0] i_MEM_RegWrAddr,
   input  logic                 i_MEM_MemAccess,
   input  logic                 i_DMemReady,
   input  logic                 i_IMemReady,
   output logic                 o_PCEnable,
   output logic                 o_IFID_Enable,
   output logic                 o_IDEX_Enable,
   output logic                 o_EXMEM_Enable,
   output logic                 o_MEMWB_Enable,
   output logic                 o_IFID_Flush,
   output logic                 o_IDEX_Flush,
   output logic                 o_MEMWB_Flush,
   output logic                 o_Fault,
   output logic [1:0]           o_State
`ifdef PIPECTRL_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] o_StallCycles,
   output logic [CNT_WIDTH-1:0] o_FlushCount,
   output logic [CNT_WIDTH-1:0] o_WaitCycles
`endif
);

   localparam int unsigned WdWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);

   PipeCtrlState       state_q;
   logic [WdWidth-1:0] wd_q;
   logic               load_use;
   logic               data_wait;

   hazard_detector #(
      .REG_WIDTH (REG_WIDTH)
   ) u_hazard_detector (
      .i_ID_RS1        (i_ID_RS1),
      .i_ID_RS2        (i_ID_RS2),
      .i_ID_UsesRS1    (i_ID_UsesRS1),
      .i_ID_UsesRS2    (i_ID_UsesRS2),
      .i_EX_IsLoad     (i_EX_IsLoad),
      .i_EX_RegWrAddr  (i_EX_RegWrAddr),
      .i_MEM_IsLoad    (i_MEM_IsLoad),
      .i_MEM_RegWrAddr (i_MEM_RegWrAddr),
      .o_LoadUse       (load_use)
   );

   assign data_wait = i_MEM_MemAccess && !i_DMemReady;

   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q <= RUN;
         wd_q    <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (data_wait) begin
                  state_q <= DMEM_WAIT;
                  wd_q    <= WdWidth'(1);
               end
            end
            DMEM_WAIT: begin
               if (i_DMemReady) begin
                  state_q <= RUN;
                  wd_q    <= '0;
               end else if (wd_q == WdLast) begin
                  state_q <= FAULT;
               end else begin
                  wd_q <= wd_q + WdWidth'(1);
               end
            end
            FAULT: ;
            default: begin
               state_q <= RUN;
               wd_q    <= '0;
            end
         endcase
      end
   end

   always_comb begin
      o_PCEnable     = 1'b0;
      o_IFID_Enable  = 1'b0;
      o_IDEX_Enable  = 1'b0;
      o_EXMEM_Enable = 1'b0;
      o_MEMWB_Enable = 1'b0;
      o_IFID_Flush   = 1'b0;
      o_IDEX_Flush   = 1'b0;
      o_MEMWB_Flush  = 1'b0;
      if (!i_Reset) begin
         o_IFID_Flush  = 1'b1;
         o_IDEX_Flush  = 1'b1;
         o_MEMWB_Flush = 1'b1;
      end else if (state_q == FAULT) begin
         // Everything frozen, nothing flushed.
      end else if (data_wait) begin
         // Only WB advances, and it takes a bubble.
         o_MEMWB_Enable = 1'b1;
         o_MEMWB_Flush  = 1'b1;
      end else if (load_use) begin
         // Redirect is ignored here: ID operands are stale.
         o_IDEX_Enable  = 1'b1;
         o_IDEX_Flush   = 1'b1;
         o_EXMEM_Enable = 1'b1;
         o_MEMWB_Enable = 1'b1;
      end else if (i_ID_Redirect) begin
         // PC takes the target even with a fetch outstanding.
         o_PCEnable     = 1'b1;
         o_IFID_Enable  = 1'b1;
         o_IDEX_Enable  = 1'b1;
         o_EXMEM_Enable = 1'b1;
         o_MEMWB_Enable = 1'b1;
         o_IFID_Flush   = 1'b1;
      end else if (!i_IMemReady) begin
         o_IFID_Enable  = 1'b1;
         o_IFID_Flush   = 1'b1;
         o_IDEX_Enable  = 1'b1;
         o_EXMEM_Enable = 1'b1;
         o_MEMWB_Enable = 1'b1;
      end else begin
         o_PCEnable     = 1'b1;
         o_IFID_Enable  = 1'b1;
         o_IDEX_Enable  = 1'b1;
         o_EXMEM_Enable = 1'b1;
         o_MEMWB_Enable = 1'b1;
      end
   end

   assign o_Fault = (state_q == FAULT);
   assign o_State = state_q;

`ifdef PIPECTRL_PERF_EN
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         o_StallCycles <= '0;
         o_FlushCount  <= '0;
         o_WaitCycles  <= '0;
      end else if (state_q != FAULT) begin
         if (!o_PCEnable && (o_StallCycles != '1)) begin
            o_StallCycles <= o_StallCycles + CNT_WIDTH'(1);
         end
         if ((o_IFID_Flush || o_IDEX_Flush) && (o_FlushCount != '1)) begin
            o_FlushCount <= o_FlushCount + CNT_WIDTH'(1);
         end
         if ((state_q == DMEM_WAIT) && (o_WaitCycles != '1)) begin
            o_WaitCycles <= o_WaitCycles + CNT_WIDTH'(1);
         end
      end
   end
`else
   // Counter width has no effect when the counters are not built.
   if (CNT_WIDTH == 0) begin : g_no_counters
   end
`endif

endmodule
